// File: rtl/serial_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per clock through a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the i_sub port, which turns the operation into A-B.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_ovf
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int SW   = (N > 1) ? WIDTH - CHUNK : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  a_work, b_work, b_load;
  logic              carry, c_load;
  logic [IDXW-1:0]   idx;
  logic [SW-1:0]     shadow, shadow_next;
  logic [WIDTH-1:0]  sum_full;
  logic [CHUNK-1:0]  ca, cb, csum;
  logic              cout, cin_msb, last, accept;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1, so i_c is overridden whenever i_sub is set.
  assign b_load = i_sub ? ~i_b : i_b;
  assign c_load = i_sub | i_c;
`else
  assign b_load = i_b;
  assign c_load = i_c;
`endif

  assign ca   = a_work[CHUNK-1:0];
  assign cb   = b_work[CHUNK-1:0];
  assign {cout, csum} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
  // Carry into the top bit of the chunk, recovered from its sum bit.
  assign cin_msb = csum[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
  assign last    = (idx == IDXW'(N - 1));
  assign accept  = i_start && (state != RUN);

  generate
    if (N > 1) begin : g_multi
      assign sum_full    = {csum, shadow};
      assign shadow_next = sum_full[WIDTH-1:CHUNK];
    end else begin : g_single
      assign sum_full    = csum;
      assign shadow_next = '0;
    end
  endgenerate

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = RUN;
      RUN:     if (last)    next_state = DONE;
      DONE:    next_state = i_start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands shift down one chunk per cycle; the shadow collects sums from the top.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_work <= '0;
      b_work <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      shadow <= '0;
      o_s    <= '0;
      o_c    <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (accept) begin
      a_work <= i_a;
      b_work <= b_load;
      carry  <= c_load;
      idx    <= '0;
      shadow <= '0;
    end else if (state == RUN) begin
      a_work <= a_work >> CHUNK;
      b_work <= b_work >> CHUNK;
      carry  <= cout;
      idx    <= idx + 1'b1;
      shadow <= shadow_next;
      if (last) begin
        o_s   <= sum_full;
        o_c   <= cout;
        o_ovf <= cin_msb ^ cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with default WIDTH=16, CHUNK=4 (N=4).
// Subtraction vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_c = 1'b0;
  logic        i_sub = 1'b0;
  logic        o_busy, o_done, o_c, o_ovf;
  logic [15:0] o_s;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  serial_adder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_a(i_a), .i_b(i_b), .i_c(i_c),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(i_sub),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_s(o_s), .o_c(o_c), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Presents one operation for a single accepting edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub);
    @(negedge i_clk);
    i_start = 1'b1; i_a = a; i_b = b; i_c = c; i_sub = sub;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_a = 16'hDEAD; i_b = 16'hBEEF; i_c = ~c; i_sub = ~sub;
  endtask

  task automatic waitDone(output int cycles, output int busy_cnt);
    cycles = 0; busy_cnt = 0;
    while (!o_done && cycles < 20) begin
      busy_cnt += int'(o_busy);
      @(posedge i_clk); #1;
      cycles++;
    end
    if (!o_done) checkOutput("done_timeout", 32'(o_done), 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic sub, input logic [15:0] es, input logic ec, input logic eovf);
    int cycles, busy_cnt;
    applyStimulus(a, b, c, sub);
    waitDone(cycles, busy_cnt);
    checkOutput({tag, "_s"}, 32'(o_s), 32'(es));
    checkOutput({tag, "_c"}, 32'(o_c), 32'(ec));
    checkOutput({tag, "_ovf"}, 32'(o_ovf), 32'(eovf));
    checkOutput({tag, "_lat"}, 32'(cycles), 32'd4);
  endtask

  initial begin
    int cycles, busy_cnt, t1, t2, seen;
    #12;
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_s", 32'(o_s), 32'd0);
    checkOutput("rst_c", 32'(o_c), 32'd0);
    checkOutput("rst_ovf", 32'(o_ovf), 32'd0);
    @(negedge i_clk); i_rst = 1'b0;

    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    waitDone(cycles, busy_cnt);
    checkOutput("basic_s", 32'(o_s), 32'h5555);
    checkOutput("basic_c", 32'(o_c), 32'd0);
    checkOutput("basic_ovf", 32'(o_ovf), 32'd0);
    checkOutput("basic_lat", 32'(cycles), 32'd4);
    checkOutput("basic_busy", 32'(busy_cnt), 32'd4);
    @(posedge i_clk); #1;
    checkOutput("idle_done", 32'(o_done), 32'd0);
    checkOutput("idle_busy", 32'(o_busy), 32'd0);
    checkOutput("hold_s", 32'(o_s), 32'h5555);

    runOp("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    runOp("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start pulsed during RUN must be ignored.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge i_clk);
    i_start = 1'b1; i_a = 16'hAAAA; i_b = 16'h5555;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    waitDone(cycles, busy_cnt);
    checkOutput("ignore_s", 32'(o_s), 32'h3333);
    checkOutput("ignore_lat", 32'(cycles), 32'd3);
    @(posedge i_clk); #1;
    checkOutput("ignore_idle", 32'(o_busy), 32'd0);

    // Start held through DONE: second operation follows N+1 cycles later.
    @(negedge i_clk);
    i_start = 1'b1; i_a = 16'h0001; i_b = 16'h0002; i_c = 1'b0;
    @(posedge i_clk); #1;
    i_a = 16'h0010; i_b = 16'h0020;
    waitDone(cycles, busy_cnt);
    t1 = cyc;
    checkOutput("b2b_first_s", 32'(o_s), 32'h0003);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    checkOutput("b2b_busy", 32'(o_busy), 32'd1);
    checkOutput("b2b_done_fall", 32'(o_done), 32'd0);
    waitDone(cycles, busy_cnt);
    t2 = cyc;
    checkOutput("b2b_second_s", 32'(o_s), 32'h0030);
    checkOutput("b2b_spacing", 32'(t2 - t1), 32'd5);

    runOp("both", 16'h8000, 16'h8001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1);

    // Asynchronous reset two cycles into RUN.
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(o_busy), 32'd0);
    checkOutput("arst_done", 32'(o_done), 32'd0);
    checkOutput("arst_s", 32'(o_s), 32'd0);
    checkOutput("arst_c", 32'(o_c), 32'd0);
    checkOutput("arst_ovf", 32'(o_ovf), 32'd0);
    @(negedge i_clk); i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      seen += int'(o_done);
    end
    checkOutput("arst_no_done", 32'(seen), 32'd0);
    runOp("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    runOp("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    runOp("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    runOp("sub_off", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder: the sequential successor to the team's single-bit half adder. It adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, through a registered carry chain. A start/busy/done handshake frames each operation, so wide additions fit in small area at high clock rates. It also reports carry-out and signed overflow.

## Interface
- WIDTH, 16, operand and sum width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock; N = WIDTH/CHUNK cycles per operation.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  request a new operation; sampled on rising edge.
- i_a  in  WIDTH  operand A; sampled with accepted i_start.
- i_b  in  WIDTH  operand B; sampled with accepted i_start.
- i_c  in  1  carry-in; sampled with accepted i_start.
- o_busy  out  1  high while an operation is in progress (state RUN).
- o_done  out  1  one-cycle pulse when a result is committed.
- o_s  out  WIDTH  sum, modulo 2^WIDTH.
- o_c  out  1  carry-out of bit WIDTH-1.
- o_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states:
  - IDLE: reset state. On i_start=1, latch i_a, i_b, i_c into working registers, clear the chunk index and go to RUN.
  - RUN: each edge adds chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of A and B plus the registered carry. The chunk sum goes into a shadow sum register and the carry register is updated. After chunk N-1, go to DONE.
  - DONE: lasts one cycle with o_done=1. On i_start=1, accept a new operation and go to RUN; otherwise go to IDLE.
- A start is accepted only in IDLE or DONE. i_start in RUN is ignored: no latch, no queue, no error.
- Result outputs:
  - o_s, o_c and o_ovf update only on the edge that completes chunk N-1, from the shadow registers.
  - They hold until the next completion; intermediate sums are never visible.
- o_ovf is computed on the last chunk: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Operands on i_a, i_b and i_c may change freely after the accepting edge.
- Reset mid-operation:
  - Aborts immediately; the state returns to IDLE.
  - All outputs, the working registers and the carry register clear to 0.
  - No o_done pulse occurs for the aborted operation.

## Timing
- Reset values: o_busy=0, o_done=0, o_s=0, o_c=0, o_ovf=0; state IDLE.
- Start accepted on edge E0. o_busy is high from after E0 through after E(N-1).
- The results and o_done=1 appear after edge EN; latency is N cycles from the accepting edge.
- With the defaults (N=4), start sampled on edge 0 gives o_done high in the cycle after edge 4.
- Back-to-back: start held high in the DONE cycle is accepted. o_done falls and o_busy rises after that edge, so the throughput is one result per N+1 cycles.
- N=1 (CHUNK=WIDTH) is legal: the design behaves as a single-cycle registered adder with a 1-cycle latency.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port i_sub (1 bit), sampled with an accepted i_start.
  - When i_sub=1: B is latched inverted and the carry-in is forced to 1, so the block computes A−B. i_c is ignored.
  - o_c=1 means no borrow; o_ovf is signed subtraction overflow.
  - When i_sub=0: behaviour is identical to the add-only build.
- SERIAL_ADDER_SUB_EN undefined: no i_sub port; the block adds only.

## Test plan
- 0x1234 + 0x4321, i_c=0, defaults -> o_s=0x5555, o_c=0, o_ovf=0, o_done exactly 4 cycles after the start edge, o_busy high 4 cycles.
- 0xFFFF + 0x0001 and 0x00FF + 0x0000 with i_c=1 -> 0x0000/o_c=1/o_ovf=0, then 0x0100/o_c=0 (carry crosses the chunk boundary).
- 0x7FFF + 0x0001 -> o_s=0x8000, o_c=0, o_ovf=1; then 0x8000 + 0x8000 -> o_s=0x0000, o_c=1, o_ovf=1.
- Start pulsed during RUN with different operands -> ignored, the original result is produced. Start held through DONE -> second operation accepted, o_done pulses N+1 cycles apart.
- i_rst asserted asynchronously after 2 RUN cycles -> all outputs 0 and o_busy=0 immediately, no o_done. The next operation, 0x0003 + 0x0004, gives o_s=0x0007.
- SERIAL_ADDER_SUB_EN defined, i_sub=1: 0x0005 − 0x0007 -> o_s=0xFFFE, o_c=0, o_ovf=0. Then 0x8000 − 0x0001 -> o_s=0x7FFF, o_c=1, o_ovf=1.
